// File: rtl/schoolbook_pkg.sv
// Shared types and sizing helpers for the digit-serial schoolbook multiplier.
// No logic; latency and backpressure are defined by the modules that import it.
package schoolbook_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int num_digits(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // A one-digit operation still needs a 1-bit counter to keep the datapath uniform.
    function automatic int cnt_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/schoolbook_pp.sv
// Partial product a x digit (N+D bits); carry-less variant when SCHOOLBOOK_CLMUL_EN is defined.
// Purely combinational, zero latency, no flow control.
module schoolbook_pp #(
    parameter int N = 283,
    parameter int D = 8
) (
    input  logic [N-1:0]   a,
    input  logic [D-1:0]   digit,
`ifdef SCHOOLBOOK_CLMUL_EN
    input  logic           clmul,
`endif
    output logic [N+D-1:0] pp
);

`ifdef SCHOOLBOOK_CLMUL_EN
    always_comb begin
        pp = '0;
        if (clmul) begin
            for (int i = 0; i < D; i++) begin
                if (digit[i]) begin
                    pp = pp ^ ((N+D)'(a) << i);
                end
            end
        end else begin
            pp = (N+D)'(a) * (N+D)'(digit);
        end
    end
`else
    always_comb begin
        pp = (N+D)'(a) * (N+D)'(digit);
    end
`endif

endmodule

// File: rtl/schoolbook_digit_serial.sv
// Digit-serial schoolbook multiplier, full 2N-bit product; mode port only with SCHOOLBOOK_CLMUL_EN.
// Latency: K = ceil(N/D) cycles accept-to-done, K+2 cycles per product.
// Backpressure: start is honoured only while ready is high; no queuing.
module schoolbook_digit_serial
    import schoolbook_pkg::*;
#(
    parameter int N = 283,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef SCHOOLBOOK_CLMUL_EN
    input  logic           mode,
`endif
    output logic           ready,
    output logic           done,
    output logic [2*N-1:0] c
);

    localparam int K  = num_digits(N, D);
    localparam int CW = cnt_width(K);
    localparam int KD = K * D;
    localparam logic [CW-1:0] CNT_LAST = CW'(K - 1);

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic [KD-1:0]  b_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] acc_d;
    logic [2*N-1:0] c_q;
    logic [CW-1:0]  cnt_q;
    logic           ready_q;
    logic           done_q;
    logic [D-1:0]   digit;
    logic [N+D-1:0] pp;
    logic [2*N-1:0] pp_sh;
`ifdef SCHOOLBOOK_CLMUL_EN
    logic           mode_q;
`endif

    // b_q is zero-extended to K*D bits, so the last digit needs no masking.
    assign digit = b_q[int'(cnt_q) * D +: D];

    schoolbook_pp #(
        .N (N),
        .D (D)
    ) u_pp (
        .a     (a_q),
        .digit (digit),
`ifdef SCHOOLBOOK_CLMUL_EN
        .clmul (mode_q),
`endif
        .pp    (pp)
    );

    assign pp_sh = (2*N)'(pp) << (int'(cnt_q) * D);

`ifdef SCHOOLBOOK_CLMUL_EN
    assign acc_d = mode_q ? (acc_q ^ pp_sh) : (acc_q + pp_sh);
`else
    assign acc_d = acc_q + pp_sh;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SCHOOLBOOK_CLMUL_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= KD'(b);
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
`ifdef SCHOOLBOOK_CLMUL_EN
                        mode_q  <= mode;
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_LAST) begin
                        c_q     <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign c     = c_q;

endmodule

// File: tb/tb_schoolbook_digit_serial.sv
// Directed checks of the digit-serial multiplier at N=8/D=3, N=283/D=8 and N=17/D=17.
// Carry-less vectors are exercised only when SCHOOLBOOK_CLMUL_EN is defined.
module tb_schoolbook_digit_serial;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic         start8;
    logic [7:0]   a8, b8;
    logic         ready8, done8;
    logic [15:0]  c8;

    logic         start283;
    logic [282:0] a283, b283;
    logic         ready283, done283;
    logic [565:0] c283;

    logic         start17;
    logic [16:0]  a17, b17;
    logic         ready17, done17;
    logic [33:0]  c17;

`ifdef SCHOOLBOOK_CLMUL_EN
    logic mode8;
    logic mode_zero = 1'b0;
`endif

    always #5 clk = ~clk;

    schoolbook_digit_serial #(.N(8), .D(3)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
`ifdef SCHOOLBOOK_CLMUL_EN
        .mode(mode8),
`endif
        .ready(ready8), .done(done8), .c(c8)
    );

    schoolbook_digit_serial #(.N(283), .D(8)) u283 (
        .clk(clk), .rst(rst), .start(start283), .a(a283), .b(b283),
`ifdef SCHOOLBOOK_CLMUL_EN
        .mode(mode_zero),
`endif
        .ready(ready283), .done(done283), .c(c283)
    );

    schoolbook_digit_serial #(.N(17), .D(17)) u17 (
        .clk(clk), .rst(rst), .start(start17), .a(a17), .b(b17),
`ifdef SCHOOLBOOK_CLMUL_EN
        .mode(mode_zero),
`endif
        .ready(ready17), .done(done17), .c(c17)
    );

    task automatic check(input string tag, input logic [565:0] obs, input logic [565:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one product on the N=8 instance; lat = edges after accept until done seen,
    // rlow = sampled cycles with ready low after accept.
    task automatic go8(input logic [7:0] ai, input logic [7:0] bi, output int lat, output int rlow);
        @(negedge clk);
        a8 = ai; b8 = bi; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~ai; b8 = ~bi;
        lat = -1; rlow = 0;
        for (int e = 1; e <= 40 && lat < 0; e++) begin
            if (!ready8) rlow++;
            @(posedge clk);
            @(negedge clk);
            if (done8) lat = e;
        end
        if (!ready8) rlow++;
        @(negedge clk);
        if (!ready8) rlow++;
    endtask

    task automatic go283(input logic [282:0] ai, input logic [282:0] bi, output int lat);
        @(negedge clk);
        a283 = ai; b283 = bi; start283 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start283 = 1'b0; a283 = '0; b283 = '0;
        lat = -1;
        for (int e = 1; e <= 100 && lat < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done283) lat = e;
        end
        @(negedge clk);
    endtask

    task automatic go17(input logic [16:0] ai, input logic [16:0] bi, output int lat);
        @(negedge clk);
        a17 = ai; b17 = bi; start17 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start17 = 1'b0; a17 = '0; b17 = '0;
        lat = -1;
        for (int e = 1; e <= 40 && lat < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done17) lat = e;
        end
        @(negedge clk);
    endtask

    initial begin
        int lat, rlow, first, second, ndone;
        logic [282:0] ones283;
        logic [565:0] exp_big;
        logic [565:0] c_first, c_second;

        rst = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start283 = 1'b0; a283 = '0; b283 = '0;
        start17 = 1'b0; a17 = '0; b17 = '0;
`ifdef SCHOOLBOOK_CLMUL_EN
        mode8 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_c8", c8, 0);
        check("reset_done8", done8, 0);
        check("reset_ready8", ready8, 1);
        check("reset_c283", c283, 0);
        rst = 1'b1;

        // N=8, D=3: K=3, last digit only partly populated
        go8(8'd255, 8'd255, lat, rlow);
        check("c8_ff_ff", c8, 16'hFE01);
        check("lat8", lat, 3);
        check("ready_low8", rlow, 4);
        go8(8'd200, 8'd100, lat, rlow);
        check("c8_200_100", c8, 16'h4E20);
        go8(8'd0, 8'd255, lat, rlow);
        check("c8_0_255", c8, 16'h0000);

        // start held high, operands scrambled while busy
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'hC3;
        first = -1; second = -1; ndone = 0; c_first = '0; c_second = '0;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done8) begin
                ndone++;
                if (first < 0) begin first = e; c_first = 566'(c8); end
                else begin second = e; c_second = 566'(c8); end
            end
            if (ready8) begin a8 = 8'd7; b8 = 8'd9; end
            else begin a8 = 8'(e * 37); b8 = 8'(e * 91 + 5); end
        end
        start8 = 1'b0;
        check("hold_first_done", first, 3);
        check("hold_second_done", second, 8);
        check("hold_done_pulses", ndone, 2);
        check("hold_c_first", c_first, 16'h008F);
        check("hold_c_second", c_second, 16'h003F);
        repeat (8) @(negedge clk);

        // reset at the second RUN edge discards the operation
        @(negedge clk);
        a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_c8", c8, 0);
        check("midrst_done8", done8, 0);
        check("midrst_ready8", ready8, 1);
        rst = 1'b1;
        go8(8'd3, 8'd5, lat, rlow);
        check("after_rst_c8", c8, 16'h000F);
        check("after_rst_lat8", lat, 3);

        // N=283, D=8: K=36, top digit holds only 3 real bits
        ones283 = '1;
        exp_big = 566'd1 - (566'd1 << 284);
        go283(ones283, ones283, lat);
        check("c283_max", c283, exp_big);
        check("lat283", lat, 36);
        go283(283'd3, 283'd5, lat);
        check("c283_3_5", c283, 566'd15);
        go283(283'd2, 283'd1 << 282, lat);
        check("c283_topbit", c283, 566'd1 << 283);
        go283(ones283, 283'd1, lat);
        check("c283_ones_1", c283, 566'(ones283));

        // N=17, D=17: K=1
        go17(17'h1FFFF, 17'h1FFFF, lat);
        check("c17_max", c17, 34'h3FFFC0001);
        check("lat17", lat, 1);
        go17(17'd12345, 17'd678, lat);
        check("c17_12345_678", c17, 34'h0007FB6F6);

`ifdef SCHOOLBOOK_CLMUL_EN
        mode8 = 1'b1;
        go8(8'h03, 8'h03, lat, rlow);
        check("clmul_3_3", c8, 16'h0005);
        mode8 = 1'b0;
        go8(8'h03, 8'h03, lat, rlow);
        check("int_3_3", c8, 16'h0009);
        mode8 = 1'b1;
        go8(8'hFF, 8'hFF, lat, rlow);
        check("clmul_ff_ff", c8, 16'h5555);
        mode8 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/schoolbook_digit_serial.md
# schoolbook_digit_serial

Parametrised digit-serial schoolbook multiplier producing the full 2N-bit product of two N-bit unsigned operands. It processes D bits of b per cycle, so one product takes K = ceil(N/D) cycles. A start/ready/done handshake replaces free-running operation. It sits in the large-integer multiplier library as the configurable area/latency trade-off point between bit-serial and fully parallel schoolbook multipliers.

## Interface
Parameters:
- N, default 283: operand width in bits, N ≥ 2.
- D, default 8: digit width (bits of b consumed per cycle), 1 ≤ D ≤ N.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- a  in  N  multiplicand; sampled on the accept edge only.
- b  in  N  multiplier; sampled on the accept edge only.
- mode  in  1  present only with SCHOOLBOOK_CLMUL_EN. 0 = integer, 1 = carry-less. Sampled on the accept edge.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when c holds a new result.
- c  out  2N  result register; holds its value until the next completion.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - ready=1.
  - On the accept edge (start=1): latch a_r=a and b_r=b zero-extended to K·D bits; clear acc (2N bits); set cnt=0; go to RUN.
- RUN, each edge:
  - acc ← acc + ((a_r × b_r[cnt·D +: D]) << cnt·D), computed mod 2^2N; the product always fits.
  - The partial product is N+D bits wide.
  - If cnt = K−1: c ← final acc value, go to DONE.
  - Otherwise cnt ← cnt+1.
- DONE: done=1 for this cycle only; go to IDLE.
- start is ignored in RUN and DONE. No queuing.
- a and b may change freely after the accept edge.
- Last digit: high bits beyond N are zero (zero-extension), so N not divisible by D is exact.
- D = N gives K=1, i.e. one RUN cycle.
- Reset (rst=0) at any time, including mid-RUN:
  - state=IDLE, cnt=0, acc=0, c=0, done=0, ready=1 in the following cycle.
  - The in-flight operation is discarded.
- Reset values: c=0, done=0, ready=1.

## Timing
- Accept edge is E0. RUN edges are E1..EK. c is updated at EK.
- done=1 and the new c are visible in the cycle after EK.
- ready=1 again one cycle later.
- Next accept is possible at edge EK+2, giving K+2 cycles per product.
- Latency from accept to done high is K cycles.
- c stays stable from EK until the next completion or reset. Consumers may sample it any time after done.

## Configuration
- Macro: SCHOOLBOOK_CLMUL_EN.
- Defined:
  - The mode port exists and mode_r is latched on accept.
  - mode_r=1 computes the GF(2)[x] product: partial products are built with AND/XOR and accumulated with XOR, with no carries.
  - The result occupies c[2N−2:0]; c[2N−1]=0.
  - mode_r=0 behaves exactly as integer mode.
- Undefined: no mode port, integer multiplication only, no XOR datapath logic.

## Structure
- Package schoolbook_pkg:
  - state enum {IDLE, RUN, DONE};
  - function num_digits(N,D) = (N+D−1)/D;
  - count width = $clog2(K) with a minimum of 1.
- Sub-module schoolbook_pp:
  - parameters N, D;
  - inputs a (N), digit (D), and clmul (only under the macro);
  - output N+D-bit partial product.
- The top level holds the FSM, counter, digit select, shift and accumulate.

## Test plan
- N=8, D=3 (K=3):
  - a=255, b=255, start pulse → done exactly 3 cycles after the accept edge, c=16'hFE01.
  - ready low for 4 cycles.
- N=283, D=8 (K=36), a=b=2^283−1 → c = 2^566 − 2^284 + 1, done 36 cycles after accept.
- Random regression over N∈{8,17,283} and D∈{1,3,8,N} with 1000 operands each → c equals the reference a·b. Covers non-divisible N and K=1.
- start held high continuously and a/b toggled during RUN → only the accept-edge operands are used. Next accept happens exactly K+2 edges later. done is one cycle wide each time.
- rst=0 at the second RUN cycle, then release → c=0, done=0, ready=1. A new product then completes correctly with no stale acc.
- With SCHOOLBOOK_CLMUL_EN, N=8:
  - a=8'h03, b=8'h03, mode=1 → c=16'h0005;
  - mode=0 → c=16'h0009;
  - a=b=8'hFF, mode=1 → c=16'h5555.
